sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO. Generalises the 8x16 FIFO: configurable width/depth,
//  simultaneous read+write in one cycle, programmable almost-full/almost-empty flags,
//  occupancy count, synchronous flush and sticky overflow/underflow error flags.
//  Used as the standard buffering stage between producer/consumer blocks in the fifo testbench tree.
// PARAMETERS
//  DATA_W   8    data word width in bits (>=1)
//  DEPTH    16   number of entries; power of 2, >=2
//  AF_LVL   14   almost_full asserts when count >= AF_LVL (1..DEPTH)
//  AE_LVL   2    almost_empty asserts when count <= AE_LVL (0..DEPTH-1)
//  CW = $clog2(DEPTH+1) (local)   AW = $clog2(DEPTH) (local)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst_n         in   1       asynchronous reset, active low
//  clr           in   1       synchronous flush (pointers/count to 0, flags cleared)
//  wr            in   1       write request
//  din           in   DATA_W  write data
//  rd            in   1       read request
//  dout          out  DATA_W  read data, registered
//  dout_valid    out  1       dout updated this cycle by an accepted read (1-cycle pulse)
//  full          out  1       count == DEPTH
//  empty         out  1       count == 0
//  almost_full   out  1       count >= AF_LVL
//  almost_empty  out  1       count <= AE_LVL
//  count         out  CW      current occupancy 0..DEPTH
//  overflow      out  1       sticky: write attempted while full
//  underflow     out  1       sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): wptr=rptr=0, count=0, dout=0, dout_valid=0, overflow=underflow=0;
//    hence empty=1, full=0, almost_empty=1, almost_full=0. Memory array not reset.
//  - Reset mid-operation discards all contents immediately; first edge after release acts normally.
//  - clr=1 (priority over wr/rd): same effect as reset on pointers, count, dout_valid, sticky
//    flags; dout holds last value; wr/rd that cycle ignored, no error flags set.
//  - wr_acc = wr & !full ; rd_acc = rd & !empty (flags evaluated from registered count).
//  - wr_acc: mem[wptr]<=din, wptr<=wptr+1 (mod DEPTH, natural AW-bit wrap).
//  - rd_acc: dout<=mem[rptr], dout_valid<=1, rptr<=rptr+1 (mod DEPTH); else dout_valid<=0, dout holds.
//  - Read latency: 1 cycle; data on dout the cycle after rd_acc.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  - Simultaneous rd+wr, 0<count<DEPTH: both accepted, count unchanged.
//  - Full + rd + wr: read accepted, write rejected, overflow<=1, count->DEPTH-1.
//  - Empty + rd + wr: write accepted, read rejected, underflow<=1, count->1, dout_valid=0
//    (no fall-through; written word readable next cycle).
//  - wr while full -> overflow<=1; rd while empty -> underflow<=1; both hold until reset/clr.
//  - Status flags combinational from registered count; change the cycle after the causing edge.
//  - count never exceeds DEPTH nor goes below 0 under any stimulus.
// TESTING (DATA_W=8, DEPTH=16, AF_LVL=14, AE_LVL=2)
//  1 Reset: rst_n=0 mid-traffic -> immediately count=0, empty=1, full=0, dout=0, dout_valid=0,
//    almost_empty=1, flags=0.
//  2 Fill/drain: write 0x00..0x0F -> full=1, count=16, almost_full at count 14; 17th write -> overflow=1,
//    count=16; 16 reads -> dout 0x00..0x0F in order, each 1 cycle after rd, empty=1 at end.
//  3 Wrap: 10 writes, 10 reads, 10 more writes (0xA0..0xA9) -> wptr wraps past 15;
//    reads return 0xA0..0xA9 in order.
//  4 Simultaneous: count=5, rd=wr=1 for 8 cycles -> count stays 5, data order preserved;
//    at full rd+wr -> count 15, overflow=1; at empty rd+wr -> count 1, underflow=1, dout_valid=0.
//  5 Thresholds: count 2->3 drops almost_empty; 13->14 raises almost_full; reverse on reads.
//  6 Flush: count=9, overflow=1, clr=1 with wr=rd=1 -> next cycle count=0, empty=1,
//    overflow=0, dout_valid=0, no data written.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level flags, occupancy and sticky errors
module sync_fifo_param #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AF_LVL = 14,
   parameter int AE_LVL = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              rd_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              dout_valid_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic [CW-1:0]     count_o,
   output logic              overflow_o,
   output logic              underflow_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;
   logic              wr_acc, rd_acc;

   assign full_o         = count_q == CW'(DEPTH);
   assign empty_o        = count_q == '0;
   assign almost_full_o  = count_q >= CW'(AF_LVL);
   assign almost_empty_o = count_q <= CW'(AE_LVL);
   assign count_o        = count_q;
   assign dout_o         = dout_q;
   assign dout_valid_o   = dv_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

   // flush overrides both requests so nothing is written or read that cycle
   assign wr_acc = wr_i & ~full_o & ~clr_i;
   assign rd_acc = rd_i & ~empty_o & ~clr_i;

   always_comb begin
      wptr_d  = clr_i ? '0 : wptr_q + AW'(wr_acc);
      rptr_d  = clr_i ? '0 : rptr_q + AW'(rd_acc);
      count_d = clr_i ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
      dout_d  = rd_acc ? mem_q[rptr_q] : dout_q;
      dv_d    = rd_acc;
      ovf_d   = ~clr_i & (ovf_q | (wr_i & full_o));
      udf_d   = ~clr_i & (udf_q | (rd_i & empty_o));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   always_ff @(posedge clk_i)
      if (wr_acc) mem_q[wptr_q] <= din_i;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed stimulus with a queue-based reference model checked every cycle
module tb_sync_fifo_param;
   logic       clk = 0, rst_n = 0, clr = 0, wr = 0, rd = 0;
   logic [7:0] din = 0, dout;
   logic       dv, full, empty, af, ae, ovf, udf;
   logic [4:0] count;
   int checks = 0, errors = 0;

   sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_i(wr), .din_i(din), .rd_i(rd),
      .dout_o(dout), .dout_valid_o(dv), .full_o(full), .empty_o(empty),
      .almost_full_o(af), .almost_empty_o(ae), .count_o(count),
      .overflow_o(ovf), .underflow_o(udf));

   always #5 clk = ~clk;

   logic [7:0] mq[$];
   logic [7:0] m_dout = 0;
   logic       m_dv = 0, m_ovf = 0, m_udf = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete(); m_dout = 0; m_dv = 0; m_ovf = 0; m_udf = 0;
      end else if (clr) begin
         mq.delete(); m_dv = 0; m_ovf = 0; m_udf = 0;
      end else begin
         automatic bit was_full = mq.size() == 16;
         automatic bit was_empty = mq.size() == 0;
         m_dv = 0;
         if (rd && !was_empty) begin m_dout = mq.pop_front(); m_dv = 1; end
         else if (rd) m_udf = 1;
         if (wr && !was_full) mq.push_back(din);
         else if (wr) m_ovf = 1;
      end
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      automatic int n = mq.size();
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("full", full, n == 16);
      chk("almost_full", af, n >= 14);
      chk("almost_empty", ae, n <= 2);
      chk("overflow", ovf, m_ovf);
      chk("underflow", udf, m_udf);
      chk("dout_valid", dv, m_dv);
      chk("dout", dout, m_dout);
   end

   task automatic step(bit w, logic [7:0] d, bit r, bit c);
      @(negedge clk);
      wr = w; din = d; rd = r; clr = c;
      @(posedge clk); #1;
   endtask

   initial begin
      #25 rst_n = 1;
      // fill / drain
      for (int i = 0; i < 16; i++) begin
         step(1, 8'(i), 0, 0);
         if (i == 12) chk("lit_af_13", af, 0);
         if (i == 13) chk("lit_af_14", af, 1);
      end
      chk("lit_full", full, 1);
      chk("lit_count16", count, 16);
      step(1, 8'h99, 0, 0);
      chk("lit_ovf", ovf, 1);
      chk("lit_count_ovf", count, 16);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 0);
         chk("lit_drain_dout", dout, i);
         chk("lit_drain_dv", dv, 1);
      end
      step(0, 0, 0, 0);
      chk("lit_empty", empty, 1);
      chk("lit_dv_low", dv, 0);
      step(0, 0, 0, 1);
      // wrap
      for (int i = 0; i < 10; i++) step(1, 8'(i), 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(1, 8'hA0 + 8'(i), 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0);
         chk("lit_wrap_dout", dout, 'hA0 + i);
      end
      // simultaneous
      for (int i = 0; i < 5; i++) step(1, 8'h50 + 8'(i), 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 8'h60 + 8'(i), 1, 0);
         chk("lit_sim_count", count, 5);
         chk("lit_sim_dout", dout, i < 5 ? 'h50 + i : 'h60 + i - 5);
      end
      for (int i = 0; i < 11; i++) step(1, 8'(i), 0, 0);
      chk("lit_full2", count, 16);
      step(1, 8'hFF, 1, 0);
      chk("lit_fullrw_count", count, 15);
      chk("lit_fullrw_ovf", ovf, 1);
      step(0, 0, 0, 1);
      step(1, 8'h77, 1, 0);
      chk("lit_emptyrw_count", count, 1);
      chk("lit_emptyrw_udf", udf, 1);
      chk("lit_emptyrw_dv", dv, 0);
      step(0, 0, 1, 0);
      chk("lit_emptyrw_dout", dout, 'h77);
      // thresholds
      step(0, 0, 0, 1);
      for (int i = 1; i <= 14; i++) begin
         step(1, 8'(i), 0, 0);
         if (i == 2) chk("lit_ae_2", ae, 1);
         if (i == 3) chk("lit_ae_3", ae, 0);
      end
      step(0, 0, 1, 0);
      chk("lit_af_down", af, 0);
      for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
      chk("lit_ae_back", ae, 1);
      // flush
      step(0, 0, 0, 1);
      for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
      chk("lit_pre_flush", count, 9);
      step(1, 8'h33, 1, 1);
      chk("lit_flush_count", count, 0);
      chk("lit_flush_ovf", ovf, 0);
      chk("lit_flush_dv", dv, 0);
      step(0, 0, 1, 0);
      chk("lit_flush_nodata", dv, 0);
      chk("lit_flush_udf", udf, 1);
      // async reset mid traffic
      step(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, 8'(i), i > 2, 0);
      #2 rst_n = 0;
      #1;
      chk("lit_rst_count", count, 0);
      chk("lit_rst_empty", empty, 1);
      chk("lit_rst_ae", ae, 1);
      chk("lit_rst_dout", dout, 0);
      chk("lit_rst_dv", dv, 0);
      wr = 0; rd = 0;
      @(negedge clk); rst_n = 1;
      step(1, 8'h42, 0, 0);
      step(0, 0, 1, 0);
      chk("lit_post_rst", dout, 'h42);
      step(0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
